// File: rtl/rs_slot_bank.sv
// Reservation-station slot bank: dispatch fills the lowest free slot, the CDB wakes
// waiting operands, and a granted ready slot is released for reuse on the next cycle.
package rs_slot_bank_pkg;
   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_MULT = 2'd1,
      FU_MEM  = 2'd2,
      FU_BR   = 2'd3
   } func_unit_t;
endpackage

module rs_slot_bank
   import rs_slot_bank_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 6
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          squash,
   input  logic                          dispatch_valid,
   input  func_unit_t                    dispatch_func,
   input  logic [TAG_W-1:0]              dispatch_tag1,
   input  logic [TAG_W-1:0]              dispatch_tag2,
   input  logic                          dispatch_rdy1,
   input  logic                          dispatch_rdy2,
   input  logic [TAG_W-1:0]              dispatch_dest,
   input  logic                          cdb_valid,
   input  logic [TAG_W-1:0]              cdb_tag,
   input  logic [WIDTH-1:0]              issue_gnt,
   output logic [WIDTH-1:0]              req,
   output func_unit_t [WIDTH-1:0]        func_out,
   output logic [WIDTH-1:0][TAG_W-1:0]   dest_out,
   output logic                          dispatch_ack,
   output logic                          full,
   output logic [$clog2(WIDTH+1)-1:0]    free_count
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]              valid_q, valid_d;
   logic [WIDTH-1:0]              rdy1_q, rdy1_d;
   logic [WIDTH-1:0]              rdy2_q, rdy2_d;
   func_unit_t [WIDTH-1:0]        func_q, func_d;
   logic [WIDTH-1:0][TAG_W-1:0]   tag1_q, tag1_d;
   logic [WIDTH-1:0][TAG_W-1:0]   tag2_q, tag2_d;
   logic [WIDTH-1:0][TAG_W-1:0]   dest_q, dest_d;
   logic [CNT_W-1:0]              used_s;
   logic [IDX_W-1:0]              alloc_idx_s;

   // Issue requests, valid-gated slot outputs and occupancy from registered state
   always_comb begin
      req      = {WIDTH{1'b0}};
      func_out = {WIDTH{FU_ALU}};
      dest_out = {(WIDTH*TAG_W){1'b0}};
      used_s   = {CNT_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (valid_q[i]) begin
            req[i]      = rdy1_q[i] & rdy2_q[i];
            func_out[i] = func_q[i];
            dest_out[i] = dest_q[i];
            used_s      = used_s + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            req[i]      = 1'b0;
            func_out[i] = FU_ALU;
            dest_out[i] = {TAG_W{1'b0}};
         end
      end
      full         = &valid_q;
      free_count   = CNT_W'(WIDTH) - used_s;
      dispatch_ack = dispatch_valid & ~full & ~squash & ~reset;
   end

   // Lowest-index free slot; scanning downward lets the lowest index win
   always_comb begin
      alloc_idx_s = {IDX_W{1'b0}};
      for (int i = WIDTH - 1; i >= 0; i--) begin
         alloc_idx_s = valid_q[i] ? alloc_idx_s : IDX_W'(i);
      end
   end

   // Next slot state: wakeup and grant on occupied slots, dispatch into the free target, squash overrides
   always_comb begin
      valid_d = valid_q;
      rdy1_d  = rdy1_q;
      rdy2_d  = rdy2_q;
      func_d  = func_q;
      tag1_d  = tag1_q;
      tag2_d  = tag2_q;
      dest_d  = dest_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (valid_q[i]) begin
            rdy1_d[i]  = rdy1_q[i] | (cdb_valid & (tag1_q[i] == cdb_tag));
            rdy2_d[i]  = rdy2_q[i] | (cdb_valid & (tag2_q[i] == cdb_tag));
            valid_d[i] = ~(issue_gnt[i] & req[i]);
         end else begin
            valid_d[i] = 1'b0;
         end
      end
      // The target slot is free at cycle start, so it never collides with a grant or wakeup
      if (dispatch_ack) begin
         valid_d[alloc_idx_s] = 1'b1;
         func_d[alloc_idx_s]  = dispatch_func;
         tag1_d[alloc_idx_s]  = dispatch_tag1;
         tag2_d[alloc_idx_s]  = dispatch_tag2;
         dest_d[alloc_idx_s]  = dispatch_dest;
         rdy1_d[alloc_idx_s]  = dispatch_rdy1 | (cdb_valid & (dispatch_tag1 == cdb_tag));
         rdy2_d[alloc_idx_s]  = dispatch_rdy2 | (cdb_valid & (dispatch_tag2 == cdb_tag));
      end else begin
         valid_d = valid_d;
      end
      if (squash) begin
         valid_d = {WIDTH{1'b0}};
      end else begin
         valid_d = valid_d;
      end
   end

   // Slot storage with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= {WIDTH{1'b0}};
         rdy1_q  <= {WIDTH{1'b0}};
         rdy2_q  <= {WIDTH{1'b0}};
         func_q  <= {WIDTH{FU_ALU}};
         tag1_q  <= {(WIDTH*TAG_W){1'b0}};
         tag2_q  <= {(WIDTH*TAG_W){1'b0}};
         dest_q  <= {(WIDTH*TAG_W){1'b0}};
      end else begin
         valid_q <= valid_d;
         rdy1_q  <= rdy1_d;
         rdy2_q  <= rdy2_d;
         func_q  <= func_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
         dest_q  <= dest_d;
      end
   end
endmodule

// File: tb/tb_rs_slot_bank.sv
// Bench for rs_slot_bank: a slot-array model is checked against the DUT every cycle,
// with directed scenarios pinning the model to hand-computed values.
module tb_rs_slot_bank;
   import rs_slot_bank_pkg::*;

   localparam int W  = 16;
   localparam int TW = 6;

   logic                 clock = 1'b0;
   logic                 reset, squash, dispatch_valid;
   func_unit_t           dispatch_func;
   logic [TW-1:0]        dispatch_tag1, dispatch_tag2, dispatch_dest, cdb_tag;
   logic                 dispatch_rdy1, dispatch_rdy2, cdb_valid;
   logic [W-1:0]         issue_gnt, req;
   func_unit_t [W-1:0]   func_out;
   logic [W-1:0][TW-1:0] dest_out;
   logic                 dispatch_ack, full;
   logic [4:0]           free_count;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   typedef struct {
      bit          v;
      bit [1:0]    f;
      bit [TW-1:0] t1, t2, d;
      bit          r1, r2;
   } slot_t;
   slot_t m [W];

   rs_slot_bank #(.WIDTH(W), .TAG_W(TW)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .dispatch_valid(dispatch_valid), .dispatch_func(dispatch_func),
      .dispatch_tag1(dispatch_tag1), .dispatch_tag2(dispatch_tag2),
      .dispatch_rdy1(dispatch_rdy1), .dispatch_rdy2(dispatch_rdy2),
      .dispatch_dest(dispatch_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .issue_gnt(issue_gnt), .req(req), .func_out(func_out), .dest_out(dest_out),
      .dispatch_ack(dispatch_ack), .full(full), .free_count(free_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] model_req();
      logic [W-1:0] r = '0;
      for (int i = 0; i < W; i++) r[i] = m[i].v & m[i].r1 & m[i].r2;
      return r;
   endfunction

   // Reference model: the slot array advanced by the rules for one clock edge
   always @(posedge clock) begin : model
      slot_t nx [W];
      int    tgt;
      nx  = m;
      tgt = -1;
      for (int i = W - 1; i >= 0; i--) if (!m[i].v) tgt = i;
      if (reset || squash) begin
         for (int i = 0; i < W; i++) begin
            nx[i].v = 1'b0;
            if (reset) begin nx[i].r1 = 1'b0; nx[i].r2 = 1'b0; end
         end
      end else begin
         for (int i = 0; i < W; i++) begin
            if (m[i].v) begin
               if (issue_gnt[i] && m[i].r1 && m[i].r2) nx[i].v = 1'b0;
               if (cdb_valid && m[i].t1 == cdb_tag) nx[i].r1 = 1'b1;
               if (cdb_valid && m[i].t2 == cdb_tag) nx[i].r2 = 1'b1;
            end
         end
         if (dispatch_valid && tgt >= 0) begin
            nx[tgt].v  = 1'b1;
            nx[tgt].f  = dispatch_func;
            nx[tgt].t1 = dispatch_tag1;
            nx[tgt].t2 = dispatch_tag2;
            nx[tgt].d  = dispatch_dest;
            nx[tgt].r1 = dispatch_rdy1 | (cdb_valid && dispatch_tag1 == cdb_tag);
            nx[tgt].r2 = dispatch_rdy2 | (cdb_valid && dispatch_tag2 == cdb_tag);
         end
      end
      m = nx;
   end

   // Compare every output against the model, away from the active edge
   always @(negedge clock) begin : compare
      logic [W-1:0]    er;
      logic [2*W-1:0]  ef;
      logic [W*TW-1:0] ed;
      int              nfree;
      if (chk_en) begin
         er    = model_req();
         ef    = '0;
         ed    = '0;
         nfree = 0;
         for (int i = 0; i < W; i++) begin
            if (m[i].v) begin
               ef[2*i +: 2]   = m[i].f;
               ed[TW*i +: TW] = m[i].d;
            end else begin
               nfree++;
            end
         end
         check("req", 128'(req), 128'(er));
         check("func_out", 128'(func_out), 128'(ef));
         check("dest_out", 128'(dest_out), 128'(ed));
         check("full", 128'(full), 128'(nfree == 0));
         check("free_count", 128'(free_count), 128'(nfree));
         check("dispatch_ack", 128'(dispatch_ack),
               128'(dispatch_valid && nfree != 0 && !squash && !reset));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      squash = 1'b0; dispatch_valid = 1'b0; dispatch_func = FU_ALU;
      dispatch_tag1 = '0; dispatch_tag2 = '0; dispatch_rdy1 = 1'b0; dispatch_rdy2 = 1'b0;
      dispatch_dest = '0; cdb_valid = 1'b0; cdb_tag = '0; issue_gnt = '0;
   endtask

   task automatic disp(input func_unit_t f, input logic [TW-1:0] t1, input logic r1,
                       input logic [TW-1:0] t2, input logic r2, input logic [TW-1:0] d);
      dispatch_valid = 1'b1; dispatch_func = f;
      dispatch_tag1 = t1; dispatch_rdy1 = r1;
      dispatch_tag2 = t2; dispatch_rdy2 = r2;
      dispatch_dest = d;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      dispatch_valid = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      @(negedge clock);
      check("rst_ack", 128'(dispatch_ack), 128'(1'b0));
      check("rst_req", 128'(req), 128'(16'h0000));
      check("rst_full", 128'(full), 128'(1'b0));
      check("rst_free", 128'(free_count), 128'(5'd16));
      reset = 1'b0;
      idle();

      // single ready ALU dispatch into an empty bank
      disp(FU_ALU, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
      tick(); idle();
      @(negedge clock);
      check("d1_req", 128'(req), 128'(16'h0001));
      check("d1_free", 128'(free_count), 128'(5'd15));

      // wakeup of operand 1 by a later broadcast
      do_reset();
      disp(FU_MULT, 6'd5, 1'b0, 6'd0, 1'b1, 6'd4);
      tick(); idle();
      @(negedge clock);
      check("wk_before", 128'(req[0]), 128'(1'b0));
      cdb_valid = 1'b1; cdb_tag = 6'd5;
      tick(); idle();
      @(negedge clock);
      check("wk_after", 128'(req[0]), 128'(1'b1));

      // same-cycle dispatch and broadcast on operand 2
      do_reset();
      disp(FU_MEM, 6'd1, 1'b1, 6'd9, 1'b0, 6'd8);
      cdb_valid = 1'b1; cdb_tag = 6'd9;
      tick(); idle();
      @(negedge clock);
      check("bypass_req", 128'(req), 128'(16'h0001));

      // fill, reject when full, grant slot 3 and refill it
      do_reset();
      for (int i = 0; i < W; i++) begin
         disp(FU_ALU, 6'd0, 1'b1, 6'd0, 1'b1, 6'(i + 1));
         tick();
      end
      disp(FU_BR, 6'd0, 1'b1, 6'd0, 1'b1, 6'd42);
      @(negedge clock);
      check("full_full", 128'(full), 128'(1'b1));
      check("full_ack", 128'(dispatch_ack), 128'(1'b0));
      issue_gnt = 16'h0008;
      tick(); idle();
      disp(FU_MEM, 6'd0, 1'b1, 6'd0, 1'b1, 6'd42);
      @(negedge clock);
      check("regrant_full", 128'(full), 128'(1'b0));
      check("regrant_ack", 128'(dispatch_ack), 128'(1'b1));
      check("regrant_free", 128'(free_count), 128'(5'd1));
      tick(); idle();
      @(negedge clock);
      check("slot3_dest", 128'(dest_out[3]), 128'(6'd42));
      check("slot3_func", 128'(func_out[3]), 128'(FU_MEM));

      // multi-grant with a grant on a non-ready slot
      do_reset();
      for (int i = 0; i < 8; i++) begin
         disp(FU_ALU, (i == 5) ? 6'd7 : 6'd0, (i != 5), 6'd0, 1'b1, 6'(i + 1));
         tick();
      end
      idle();
      @(negedge clock);
      check("mg_free_before", 128'(free_count), 128'(5'd8));
      issue_gnt = 16'h00A4;
      tick(); idle();
      @(negedge clock);
      check("mg_free_after", 128'(free_count), 128'(5'd10));
      check("mg_req", 128'(req), 128'(16'h005B));
      check("mg_slot5", 128'(dest_out[5]), 128'(6'd6));

      // squash beats a concurrent dispatch
      do_reset();
      for (int i = 0; i < 8; i++) begin
         disp(FU_MULT, 6'd0, 1'b1, 6'd0, 1'b0, 6'(i));
         tick();
      end
      disp(FU_ALU, 6'd0, 1'b1, 6'd0, 1'b1, 6'd1);
      squash = 1'b1;
      @(negedge clock);
      check("sq_ack", 128'(dispatch_ack), 128'(1'b0));
      tick(); idle();
      @(negedge clock);
      check("sq_free", 128'(free_count), 128'(5'd16));
      check("sq_req", 128'(req), 128'(16'h0000));

      // randomized traffic, including occasional mid-run reset and squash
      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 199) == 0);
         squash         = ($urandom_range(0, 59) == 0);
         dispatch_valid = ($urandom_range(0, 9) < 7);
         dispatch_func  = func_unit_t'($urandom_range(0, 3));
         dispatch_tag1  = 6'($urandom_range(0, 7));
         dispatch_tag2  = 6'($urandom_range(0, 7));
         dispatch_rdy1  = 1'($urandom);
         dispatch_rdy2  = 1'($urandom);
         dispatch_dest  = 6'($urandom);
         cdb_valid      = 1'($urandom);
         cdb_tag        = 6'($urandom_range(0, 7));
         issue_gnt      = (model_req() & 16'($urandom) & 16'($urandom)) |
                          (($urandom_range(0, 3) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();
      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
